// File: rtl/bsg_cgol_ctrl.sv
// bsg_cgol_ctrl: controller for a Game of Life board.
// It accepts a board and a generation count, loads the board into the cells,
// enables the cells for that many generations, and then presents the result.
//
// Ports:
//   clk_i, reset_i  - clock and asynchronous active-high reset
//   v_i, ready_o    - load request handshake (data_i board, frames_i count)
//   en_o            - simulate enable broadcast to every cell
//   update_o        - load strobe broadcast to every cell
//   update_val_o    - captured board driven to the cells
//   cells_i         - current cell states returned from the board
//   v_o, yumi_i     - result handshake (data_o = cells_i while v_o is high)
module bsg_cgol_ctrl #(
  parameter int unsigned cells_p       = 64,
  parameter int unsigned frame_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [cells_p-1:0]       data_i,
  input  logic [frame_width_p-1:0] frames_i,
  output logic                     ready_o,
  output logic                     en_o,
  output logic                     update_o,
  output logic [cells_p-1:0]       update_val_o,
  input  logic [cells_p-1:0]       cells_i,
  output logic                     v_o,
  output logic [cells_p-1:0]       data_o,
  input  logic                     yumi_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                   r_state;
  logic [frame_width_p-1:0] r_cnt;
  logic [cells_p-1:0]       r_board;
  logic                     r_ready;
  logic                     r_en;
  logic                     r_update;
  logic                     r_v;

  // A count of 1 or 0 in RUN means this is the last enabled generation.
  logic w_last;
  assign w_last = (r_cnt == frame_width_p'(1)) || (r_cnt == '0);

  // State machine; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_board  <= '0;
      r_ready  <= 1'b1;
      r_en     <= 1'b0;
      r_update <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (v_i) begin
            r_board  <= data_i;
            r_cnt    <= frames_i;
            r_state  <= S_LOAD;
            r_ready  <= 1'b0;
            r_update <= 1'b1;
          end
        end
        S_LOAD: begin
          r_update <= 1'b0;
          if (r_cnt != '0) begin
            r_state <= S_RUN;
            r_en    <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_v     <= 1'b1;
          end
        end
        S_RUN: begin
          // Guarded decrement so the counter can never wrap below zero.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - frame_width_p'(1);
          end
          if (w_last) begin
            r_state <= S_DONE;
            r_en    <= 1'b0;
            r_v     <= 1'b1;
          end
        end
        S_DONE: begin
          if (yumi_i) begin
            r_state <= S_IDLE;
            r_v     <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_ready  <= 1'b1;
          r_en     <= 1'b0;
          r_update <= 1'b0;
          r_v      <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o      = r_ready;
  assign en_o         = r_en;
  assign update_o     = r_update;
  assign v_o          = r_v;
  assign update_val_o = r_board;
  // Result is the live board, passed straight through.
  assign data_o       = cells_i;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// tb_bsg_cgol_ctrl: self-checking bench for bsg_cgol_ctrl with a behavioural
// 8x8 Game of Life board attached to the controller outputs.
module tb_bsg_cgol_ctrl;

  localparam int unsigned CELLS = 64;
  localparam int unsigned FW    = 16;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000; // row 3, cols 2-4
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000; // col 3, rows 2-4
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600; // 2x2 still life

  logic             clk = 1'b0;
  logic             reset_i;
  logic             v_i;
  logic [CELLS-1:0] data_i;
  logic [FW-1:0]    frames_i;
  logic             ready_o;
  logic             en_o;
  logic             update_o;
  logic [CELLS-1:0] update_val_o;
  logic [CELLS-1:0] cells_i = '0;
  logic             v_o;
  logic [CELLS-1:0] data_o;
  logic             yumi_i;

  int total = 0;
  int bad   = 0;

  bsg_cgol_ctrl #(.cells_p(CELLS), .frame_width_p(FW)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .frames_i     (frames_i),
    .ready_o      (ready_o),
    .en_o         (en_o),
    .update_o     (update_o),
    .update_val_o (update_val_o),
    .cells_i      (cells_i),
    .v_o          (v_o),
    .data_o       (data_o),
    .yumi_i       (yumi_i)
  );

  always #5 clk = ~clk;

  // One Life generation on a bounded 8x8 board (cells off the edge are dead).
  function automatic logic [63:0] life_step(input logic [63:0] b);
    logic [63:0] nb;
    int n;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8) begin
              n += int'(b[(r + dr) * 8 + c + dc]);
            end
          end
        end
        nb[r * 8 + c] = (n == 3) || (b[r * 8 + c] && n == 2);
      end
    end
    return nb;
  endfunction

  function automatic logic [63:0] life_n(input logic [63:0] b, input int f);
    logic [63:0] x;
    x = b;
    for (int i = 0; i < f; i++) x = life_step(x);
    return x;
  endfunction

  // Board model: load on update strobe, advance one generation per enable.
  always @(posedge clk) begin
    if (update_o) cells_i <= update_val_o;
    else if (en_o) cells_i <= life_step(cells_i);
  end

  // Mutual-exclusion invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (reset_i === 1'b0) begin
      total++;
      if ((en_o && update_o) || (ready_o && v_o)) begin
        bad++;
        $display("FAIL invariant t=%0t en=%b update=%b ready=%b v=%b", $time, en_o, update_o, ready_o, v_o);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Wait (bounded) for ready, then present one request across a clock edge.
  task automatic start_req(input logic [63:0] d, input logic [15:0] f, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    check({name, "_ready"}, 64'(seen), 64'd1);
    v_i      = 1'b1;
    data_i   = d;
    frames_i = f;
    @(posedge clk);
    #1 v_i = 1'b0;
  endtask

  // Called right after the handshake edge: checks latency, pulse counts and result.
  task automatic wait_result(input logic [15:0] f, input logic [63:0] exp, input string name, input bit ack);
    int cyc, en_n, up_n;
    bit got;
    cyc = 0; en_n = 0; up_n = 0; got = 1'b0;
    for (int k = 0; k < 70000 && !got; k++) begin
      @(negedge clk);
      if (v_o) got = 1'b1;
      else begin
        cyc++;
        if (en_o) en_n++;
        if (update_o) up_n++;
      end
    end
    check({name, "_vo_seen"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(cyc), 64'(f) + 64'd1);
    check({name, "_en_cycles"}, 64'(en_n), 64'(f));
    check({name, "_update_cycles"}, 64'(up_n), 64'd1);
    check({name, "_data"}, data_o, exp);
    if (ack) begin
      yumi_i = 1'b1;
      @(posedge clk);
      #1 yumi_i = 1'b0;
      @(negedge clk);
      check({name, "_ready_after"}, 64'(ready_o), 64'd1);
      check({name, "_vo_after"}, 64'(v_o), 64'd0);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [15:0] frames;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] rd;
    logic [15:0] rf;

    vecs[0] = '{data: BLINK_H, frames: 16'd1, exp: BLINK_V};
    vecs[1] = '{data: BLINK_H, frames: 16'd2, exp: BLINK_H};
    vecs[2] = '{data: 64'hDEAD_BEEF_0123_4567, frames: 16'd0, exp: 64'hDEAD_BEEF_0123_4567};
    vecs[3] = '{data: BLOCK, frames: 16'd3, exp: BLOCK};
    vecs[4] = '{data: BLINK_V, frames: 16'd3, exp: BLINK_H};

    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; frames_i = '0;
    #1;
    check("rst_en", 64'(en_o), 64'd0);
    check("rst_update", 64'(update_o), 64'd0);
    check("rst_vo", 64'(v_o), 64'd0);
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(ready_o), 64'd1);
    check("post_rst_vo", 64'(v_o), 64'd0);
    check("post_rst_board", update_val_o, 64'd0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      start_req(vecs[i].data, vecs[i].frames, $sformatf("vec%0d", i));
      wait_result(vecs[i].frames, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);
    end

    // Random boards against the reference model.
    for (int i = 0; i < 6; i++) begin
      rd = {$urandom, $urandom};
      rf = 16'($urandom_range(0, 12));
      start_req(rd, rf, $sformatf("rnd%0d", i));
      wait_result(rf, life_n(rd, int'(rf)), $sformatf("rnd%0d", i), 1'b1);
    end

    // Backpressure: result held while a new request waits.
    start_req(BLINK_H, 16'd1, "bp");
    wait_result(16'd1, BLINK_V, "bp", 1'b0);
    v_i = 1'b1; data_i = BLOCK; frames_i = 16'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_vo", 64'(v_o), 64'd1);
      check("bp_hold_ready", 64'(ready_o), 64'd0);
      check("bp_hold_data", data_o, BLINK_V);
    end
    yumi_i = 1'b1;
    @(posedge clk);
    #1 yumi_i = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", 64'(ready_o), 64'd1);
    check("bp_idle_vo", 64'(v_o), 64'd0);
    @(posedge clk);
    #1 v_i = 1'b0;
    wait_result(16'd0, BLOCK, "bp2", 1'b1);

    // Reset mid-RUN; stray yumi during RUN must be ignored.
    start_req(BLINK_H, 16'd100, "rr");
    repeat (5) @(negedge clk);
    yumi_i = 1'b1;
    repeat (5) @(negedge clk);
    check("rr_yumi_ignored_en", 64'(en_o), 64'd1);
    yumi_i = 1'b0;
    repeat (10) @(negedge clk);
    check("rr_en_before", 64'(en_o), 64'd1);
    #2 reset_i = 1'b1;
    #1;
    check("rr_en_async", 64'(en_o), 64'd0);
    check("rr_update_async", 64'(update_o), 64'd0);
    check("rr_vo_async", 64'(v_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_quiet_en", 64'(en_o), 64'd0);
      check("rr_idle_ready", 64'(ready_o), 64'd1);
    end
    start_req(BLINK_H, 16'd1, "rr_after");
    wait_result(16'd1, BLINK_V, "rr_after", 1'b1);

    // Reset in DONE discards the pending result and clears the board register.
    start_req(BLINK_H, 16'd2, "rd");
    wait_result(16'd2, BLINK_H, "rd", 1'b0);
    #2 reset_i = 1'b1;
    #1;
    check("rd_vo_async", 64'(v_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("rd_ready", 64'(ready_o), 64'd1);
    check("rd_vo", 64'(v_o), 64'd0);
    check("rd_board_clear", update_val_o, 64'd0);

    // Maximum count runs in full without wrapping.
    start_req(BLOCK, 16'hFFFF, "max");
    wait_result(16'hFFFF, BLOCK, "max", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
